// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: aluop codes and FSM state encoding.
package mem_stage_pkg;

  localparam logic [7:0] ALUOP_BUBBLE = 8'h11;
  localparam logic [7:0] ALUOP_LB     = 8'h90;
  localparam logic [7:0] ALUOP_LBU    = 8'h91;
  localparam logic [7:0] ALUOP_LH     = 8'h92;
  localparam logic [7:0] ALUOP_LHU    = 8'h93;
  localparam logic [7:0] ALUOP_LW     = 8'h94;
  localparam logic [7:0] ALUOP_SB     = 8'h98;
  localparam logic [7:0] ALUOP_SH     = 8'h99;
  localparam logic [7:0] ALUOP_SW     = 8'h9A;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } acc_size_t;

  function automatic logic is_load(input logic [7:0] op);
    return (op == ALUOP_LB) || (op == ALUOP_LBU) || (op == ALUOP_LH) ||
           (op == ALUOP_LHU) || (op == ALUOP_LW);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == ALUOP_SB) || (op == ALUOP_SH) || (op == ALUOP_SW);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus: request/ack handshake between the MEM stage and memory.
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half of the read word and sign/zero extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Lane selection followed by extension according to the load flavour.
  always_comb begin
    byte_s = rdata[7:0];
    case (lane)
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    half_s = lane[1] ? rdata[31:16] : rdata[15:0];

    case (aluop)
      ALUOP_LB:  data = 32'(byte_s);
      ALUOP_LBU: data = {24'd0, $unsigned(byte_s)};
      ALUOP_LH:  data = 32'(half_s);
      ALUOP_LHU: data = {16'd0, $unsigned(half_s)};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS32 memory-access stage: bus handshake, stall generation, load
// alignment and the MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  mem_aluop,
  input  logic [4:0]  mem_wa,
  input  logic [31:0] mem_wd,
  input  logic        mem_wreg,
  input  logic        mem_mreg,
  input  logic        mem_whilo,
  input  logic [31:0] mem_din,
  input  logic [63:0] mem_hilo,
  mem_stage_if.master dm,
  output logic        stallreq_mem,
  output logic [4:0]  fwd_wa,
  output logic        fwd_wreg,
  output logic [31:0] fwd_wd,
  output logic [4:0]  wb_wa,
  output logic        wb_wreg,
  output logic [31:0] wb_wd,
  output logic        wb_whilo,
  output logic [63:0] wb_hilo,
  output logic        wb_misalign
);

  mem_state_t state, state_nxt;
  acc_size_t  size;
  logic       ld, st, misalign, access, req;
  logic [1:0] lane;
  logic [3:0] be;
  logic [31:0] wdata, load_data;

  assign lane = mem_wd[1:0];
  assign ld   = is_load(mem_aluop);
  assign st   = is_store(mem_aluop);

  // Access width decode and alignment check.
  always_comb begin
    size = SZ_NONE;
    case (mem_aluop)
      ALUOP_LB, ALUOP_LBU, ALUOP_SB: size = SZ_BYTE;
      ALUOP_LH, ALUOP_LHU, ALUOP_SH: size = SZ_HALF;
      ALUOP_LW, ALUOP_SW:            size = SZ_WORD;
      default:                       size = SZ_NONE;
    endcase
    misalign = ((size == SZ_HALF) && lane[0]) ||
               ((size == SZ_WORD) && (lane != 2'b00));
    access   = (ld || st) && !misalign;
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be    = 4'b0000;
    wdata = mem_din;
    case (mem_aluop)
      ALUOP_SB: begin
        be    = 4'b0001 << lane;
        wdata = {4{mem_din[7:0]}};
      end
      ALUOP_SH: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{mem_din[15:0]}};
      end
      ALUOP_SW: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
  end

  // FSM state register; reset aborts any outstanding access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state, bus request and stall; an ack with no request is ignored.
  always_comb begin
    state_nxt    = state;
    req          = 1'b0;
    stallreq_mem = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          req = 1'b1;
          if (!dm.dm_ack) begin
            stallreq_mem = 1'b1;
            state_nxt    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        req          = 1'b1;
        stallreq_mem = !dm.dm_ack;
        if (dm.dm_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Gating with rst_n makes the request fall the moment reset asserts.
  assign dm.dm_req   = req && rst_n;
  assign dm.dm_we    = st;
  assign dm.dm_be    = be;
  assign dm.dm_addr  = {mem_wd[31:2], 2'b00};
  assign dm.dm_wdata = wdata;

  mem_load_align u_align (
    .aluop (mem_aluop),
    .lane  (lane),
    .rdata (dm.dm_rdata),
    .data  (load_data)
  );

  assign fwd_wa   = mem_wa;
  assign fwd_wreg = mem_wreg && !misalign;
  assign fwd_wd   = (ld && mem_mreg) ? load_data : mem_wd;

  // MEM/WB register: bubble while stalled, otherwise capture the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_wa       <= 5'd0;
      wb_wreg     <= 1'b0;
      wb_wd       <= 32'd0;
      wb_whilo    <= 1'b0;
      wb_hilo     <= 64'd0;
      wb_misalign <= 1'b0;
    end else if (stallreq_mem) begin
      wb_wa       <= 5'd0;
      wb_wreg     <= 1'b0;
      wb_wd       <= 32'd0;
      wb_whilo    <= 1'b0;
      wb_hilo     <= 64'd0;
      wb_misalign <= 1'b0;
    end else begin
      wb_wa       <= fwd_wa;
      wb_wreg     <= fwd_wreg;
      wb_wd       <= fwd_wd;
      wb_whilo    <= mem_whilo && !misalign;
      wb_hilo     <= mem_hilo;
      wb_misalign <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized accesses against a
// word-array memory model and rule-based expected results.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mem_aluop;
  logic [4:0]  mem_wa;
  logic [31:0] mem_wd;
  logic        mem_wreg;
  logic        mem_mreg;
  logic        mem_whilo;
  logic [31:0] mem_din;
  logic [63:0] mem_hilo;
  logic        stallreq_mem;
  logic [4:0]  fwd_wa, wb_wa;
  logic        fwd_wreg, wb_wreg, wb_whilo, wb_misalign;
  logic [31:0] fwd_wd, wb_wd;
  logic [63:0] wb_hilo;

  mem_stage_if dm();

  mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_aluop    (mem_aluop),
    .mem_wa       (mem_wa),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_mreg     (mem_mreg),
    .mem_whilo    (mem_whilo),
    .mem_din      (mem_din),
    .mem_hilo     (mem_hilo),
    .dm           (dm),
    .stallreq_mem (stallreq_mem),
    .fwd_wa       (fwd_wa),
    .fwd_wreg     (fwd_wreg),
    .fwd_wd       (fwd_wd),
    .wb_wa        (wb_wa),
    .wb_wreg      (wb_wreg),
    .wb_wd        (wb_wd),
    .wb_whilo     (wb_whilo),
    .wb_hilo      (wb_hilo),
    .wb_misalign  (wb_misalign)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] mem [0:255];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Access width in bytes, 0 for non-memory ops.
  function automatic int nbytes(input logic [7:0] op);
    case (op)
      8'h90, 8'h91, 8'h98: return 1;
      8'h92, 8'h93, 8'h99: return 2;
      8'h94, 8'h9A:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic logic [31:0] ld_val(input logic [7:0] op, input logic [31:0] w,
                                          input logic [1:0] lane);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * lane)) & 32'hFF;
    h = (w >> (lane[1] ? 16 : 0)) & 32'hFFFF;
    case (op)
      8'h90:   return (b >= 128) ? b + 32'hFFFFFF00 : b;
      8'h91:   return b;
      8'h92:   return (h >= 32768) ? h + 32'hFFFF0000 : h;
      8'h93:   return h;
      default: return w;
    endcase
  endfunction

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] din,
                       input logic [4:0] wa, input logic wreg, input logic whilo,
                       input logic [63:0] hilo);
    mem_aluop = op;
    mem_wd    = addr;
    mem_din   = din;
    mem_wa    = wa;
    mem_wreg  = wreg;
    mem_whilo = whilo;
    mem_hilo  = hilo;
    mem_mreg  = (op >= 8'h90 && op <= 8'h94);
  endtask

  // One instruction through the stage; lat = ack delay in cycles after the first request cycle.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] din,
                        input logic [4:0] wa, input logic wreg, input logic whilo,
                        input logic [63:0] hilo, input int lat);
    int          nb;
    bit          ld, st, mis, acc;
    int          cyc, idx;
    logic [1:0]  lane;
    logic [3:0]  ebe;
    logic [31:0] ewdata, res;
    nb   = nbytes(op);
    ld   = (op >= 8'h90 && op <= 8'h94);
    st   = (op >= 8'h98 && op <= 8'h9A);
    lane = addr[1:0];
    mis  = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
    acc  = (nb != 0) && !mis;
    cyc  = acc ? lat : 0;
    idx  = int'(addr[9:2]);
    ebe  = (nb == 1) ? (4'b0001 << lane) : (nb == 2) ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    ewdata = (nb == 1) ? din[7:0] * 32'h01010101 : (nb == 2) ? din[15:0] * 32'h00010001 : din;
    res  = addr;
    for (int k = 0; k <= cyc; k++) begin
      @(negedge clk);
      drive(op, addr, din, wa, wreg, whilo, hilo);
      dm.dm_ack   = acc ? (k == cyc) : 1'($urandom_range(0, 1));
      dm.dm_rdata = (acc && k == cyc) ? mem[idx] : $urandom;
      #1;
      chk("dm_req", dm.dm_req, acc);
      chk("stallreq_mem", stallreq_mem, acc && (k < cyc));
      if (acc) begin
        chk("dm_addr", dm.dm_addr, {addr[31:2], 2'b00});
        chk("dm_we", dm.dm_we, st);
        if (st) begin
          chk("dm_be", dm.dm_be, ebe);
          chk("dm_wdata", dm.dm_wdata, ewdata);
        end
      end
      if (k == cyc) begin
        if (ld) res = ld_val(op, mem[idx], lane);
        if (!mis) chk("fwd_wd", fwd_wd, res);
        chk("fwd_wreg", fwd_wreg, wreg && !mis);
        if (acc && st)
          for (int i = 0; i < 4; i++)
            if (ebe[i]) mem[idx][8*i +: 8] = ewdata[8*i +: 8];
      end
      @(posedge clk);
      #1;
      if (k < cyc) begin
        chk("wb_bubble", {wb_wa, wb_wreg, wb_whilo, wb_misalign}, 8'd0);
        chk("wb_bubble_wd", wb_wd, 32'd0);
        chk("wb_bubble_hilo", wb_hilo, 64'd0);
      end else begin
        if (!mis) chk("wb_wd", wb_wd, res);
        chk("wb_wreg", wb_wreg, wreg && !mis);
        chk("wb_wa", wb_wa, wa);
        chk("wb_whilo", wb_whilo, whilo && !mis);
        chk("wb_hilo", wb_hilo, hilo);
        chk("wb_misalign", wb_misalign, mis);
      end
    end
  endtask

  logic [7:0] ops [10] = '{8'h90, 8'h91, 8'h92, 8'h93, 8'h94,
                           8'h98, 8'h99, 8'h9A, 8'h21, 8'h11};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst_n = 1'b0;
    dm.dm_ack = 1'b0;
    dm.dm_rdata = 32'd0;
    drive(8'h94, 32'h100, 32'd0, 5'd3, 1'b1, 1'b0, 64'd0);

    // Reset state, with an aligned access pending at the inputs.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm_req", dm.dm_req, 1'b0);
    chk("rst_wb_ctl", {wb_wa, wb_wreg, wb_whilo, wb_misalign}, 8'd0);
    chk("rst_wb_wd", wb_wd, 32'd0);
    chk("rst_wb_hilo", wb_hilo, 64'd0);
    @(negedge clk);
    drive(8'h11, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 64'd0);
    rst_n = 1'b1;

    // Directed scenarios.
    mem[8'h40] = 32'hDEADBEEF;
    run_op(8'h94, 32'h100, 32'd0, 5'd4, 1'b1, 1'b0, 64'd0, 0);
    chk("lw_value", wb_wd, 32'hDEADBEEF);
    mem[8'h40] = 32'h80123456;
    run_op(8'h90, 32'h103, 32'd0, 5'd5, 1'b1, 1'b0, 64'd0, 3);
    chk("lb_value", wb_wd, 32'hFFFFFF80);
    run_op(8'h91, 32'h103, 32'd0, 5'd6, 1'b1, 1'b0, 64'd0, 1);
    chk("lbu_value", wb_wd, 32'h00000080);
    run_op(8'h99, 32'h22, 32'h0000ABCD, 5'd0, 1'b0, 1'b0, 64'd0, 2);
    run_op(8'h94, 32'h101, 32'd0, 5'd7, 1'b1, 1'b1, 64'h1234, 0);
    run_op(8'h21, 32'h5, 32'd0, 5'd8, 1'b1, 1'b0, 64'd0, 0);
    run_op(8'h11, 32'h0, 32'd0, 5'd0, 1'b0, 1'b0, 64'd0, 0);

    // Reset asserted while the FSM waits for an ack.
    @(negedge clk);
    drive(8'h94, 32'h40, 32'd0, 5'd9, 1'b1, 1'b0, 64'd0);
    dm.dm_ack = 1'b0;
    #1;
    chk("wait_req", dm.dm_req, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("wait_stall", stallreq_mem, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_req", dm.dm_req, 1'b0);
    chk("abort_wb", {wb_wa, wb_wreg, wb_whilo, wb_misalign}, 8'd0);
    @(negedge clk);
    drive(8'h11, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_after_rst", {dm.dm_req, stallreq_mem}, 2'b00);
    run_op(8'h94, 32'h40, 32'd0, 5'd10, 1'b1, 1'b0, 64'd0, 1);

    // Randomized traffic, back to back.
    for (int n = 0; n < 120; n++) begin
      logic [7:0] op;
      op = ops[$urandom_range(0, 9)];
      run_op(op, 32'($urandom_range(0, 1023)), $urandom, 5'($urandom),
             (op == 8'h11) ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
